// File: rtl/mep_pkg.sv
// rtl/mep_pkg.sv - edge-mode constants, channel state encoding and edge qualifier
package mep_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PULSE   = 2'b01,
    ST_HOLDOFF = 2'b10
  } mep_state_e;

  // cur is the synchronised level, prev the level one cycle earlier
  function automatic logic edge_hit(input logic [1:0] mode, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_BOTH: hit = cur ^ prev;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mep_channel.sv
// rtl/mep_channel.sv - one pulser channel: synchroniser, edge detect, pulse/hold-off FSM, missed flag
module mep_channel
  import mep_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 8,
  parameter int HOLD_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in,
  input  logic [1:0]        i_edge_mode,
  input  logic              i_retrig,
  input  logic [LEN_W-1:0]  i_pulse_len,
  input  logic [HOLD_W-1:0] i_holdoff,
  input  logic              i_clr_missed,
  output logic              o_pulse,
  output logic              o_busy,
  output logic              o_missed
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CNT_W  = (LEN_W > HOLD_W) ? LEN_W : HOLD_W;

  logic [SYNC_N-1:0] sync;
  logic              prev;
  mep_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [HOLD_W-1:0] hold;

  logic              edge_det;
  logic              drop;
  logic [LEN_W-1:0]  len_m1;
  logic [HOLD_W-1:0] hold_m1;
  logic [CNT_W-1:0]  len_load;
  logic [CNT_W-1:0]  hold_load;

  // counters hold "cycles remaining minus one"; a zero length still gives one cycle
  assign len_m1    = (i_pulse_len == '0) ? '0 : i_pulse_len - LEN_W'(1);
  assign hold_m1   = hold - HOLD_W'(1);
  assign len_load  = CNT_W'(len_m1);
  assign hold_load = CNT_W'(hold_m1);

  assign edge_det = edge_hit(i_edge_mode, sync[SYNC_N-1], prev);
  assign drop     = edge_det & (((state == ST_PULSE) & ~i_retrig) | (state == ST_HOLDOFF));

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync     <= '0;
      prev     <= 1'b0;
      state    <= ST_IDLE;
      cnt      <= '0;
      hold     <= '0;
      o_pulse  <= 1'b0;
      o_busy   <= 1'b0;
      o_missed <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_N-2:0], i_in};
      prev     <= sync[SYNC_N-1];
      o_missed <= drop | (o_missed & ~i_clr_missed);
      case (state)
        ST_IDLE: begin
          if (edge_det) begin
            state   <= ST_PULSE;
            cnt     <= len_load;
            hold    <= i_holdoff;
            o_pulse <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        ST_PULSE: begin
          // a retrigger wins even on the final pulse cycle
          if (edge_det && i_retrig) begin
            cnt <= len_load;
          end else if (cnt == '0) begin
            o_pulse <= 1'b0;
            if (hold != '0) begin
              state <= ST_HOLDOFF;
              cnt   <= hold_load;
            end else begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (cnt == '0) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_pulse <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_edge_pulser.sv
// rtl/multi_edge_pulser.sv - N-channel edge-to-pulse generator with hold-off and missed-edge flags
module multi_edge_pulser
  import mep_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 8,
  parameter int HOLD_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_CH-1:0]   i_in,
  input  logic [1:0]        i_edge_mode,
  input  logic              i_retrig,
  input  logic [LEN_W-1:0]  i_pulse_len,
  input  logic [HOLD_W-1:0] i_holdoff,
  input  logic [N_CH-1:0]   i_clr_missed,
  output logic [N_CH-1:0]   o_pulse,
  output logic [N_CH-1:0]   o_busy,
  output logic [N_CH-1:0]   o_missed
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mep_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .LEN_W       (LEN_W),
      .HOLD_W      (HOLD_W)
    ) u_ch (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_in         (i_in[g]),
      .i_edge_mode  (i_edge_mode),
      .i_retrig     (i_retrig),
      .i_pulse_len  (i_pulse_len),
      .i_holdoff    (i_holdoff),
      .i_clr_missed (i_clr_missed[g]),
      .o_pulse      (o_pulse[g]),
      .o_busy       (o_busy[g]),
      .o_missed     (o_missed[g])
    );
  end

endmodule

// File: tb/tb_multi_edge_pulser.sv
// tb/tb_multi_edge_pulser.sv - directed and random bench for multi_edge_pulser against a cycle-count model
module tb_multi_edge_pulser;

  localparam int N_CH = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LEN_W = 8;
  localparam int HOLD_W = 8;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic [N_CH-1:0]   i_in;
  logic [1:0]        i_edge_mode;
  logic              i_retrig;
  logic [LEN_W-1:0]  i_pulse_len;
  logic [HOLD_W-1:0] i_holdoff;
  logic [N_CH-1:0]   i_clr_missed;
  logic [N_CH-1:0]   o_pulse;
  logic [N_CH-1:0]   o_busy;
  logic [N_CH-1:0]   o_missed;

  multi_edge_pulser #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .LEN_W(LEN_W), .HOLD_W(HOLD_W)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_in(i_in), .i_edge_mode(i_edge_mode),
    .i_retrig(i_retrig), .i_pulse_len(i_pulse_len), .i_holdoff(i_holdoff),
    .i_clr_missed(i_clr_missed), .o_pulse(o_pulse), .o_busy(o_busy), .o_missed(o_missed)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  int tick_no = 0;

  // model: sampled input history plus remaining pulse / hold-off cycle counts
  logic [SYNC_STAGES:0] m_hist [N_CH];
  int   m_pulse [N_CH];
  int   m_hold  [N_CH];
  int   m_hlat  [N_CH];
  logic m_missed [N_CH];
  int   pulse_cnt [N_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic cur, old, ev, drop;
    int   leff;
    leff = (i_pulse_len == '0) ? 1 : int'(i_pulse_len);
    for (int c = 0; c < N_CH; c++) begin
      if (!i_reset) begin
        m_hist[c] = '0; m_pulse[c] = 0; m_hold[c] = 0; m_hlat[c] = 0; m_missed[c] = 1'b0;
      end else begin
        cur = m_hist[c][SYNC_STAGES-1];
        old = m_hist[c][SYNC_STAGES];
        case (i_edge_mode)
          2'b00: ev = cur & ~old;
          2'b01: ev = ~cur & old;
          2'b10: ev = cur ^ old;
          default: ev = 1'b0;
        endcase
        drop = 1'b0;
        if (m_pulse[c] > 0) begin
          if (ev && i_retrig) m_pulse[c] = leff;
          else begin
            drop = ev;
            m_pulse[c]--;
            if (m_pulse[c] == 0) m_hold[c] = m_hlat[c];
          end
        end else if (m_hold[c] > 0) begin
          drop = ev;
          m_hold[c]--;
        end else if (ev) begin
          m_pulse[c] = leff;
          m_hlat[c] = int'(i_holdoff);
        end
        m_missed[c] = drop ? 1'b1 : (i_clr_missed[c] ? 1'b0 : m_missed[c]);
        m_hist[c] = {m_hist[c][SYNC_STAGES-1:0], i_in[c]};
      end
    end
  endtask

  task automatic tick();
    logic [N_CH-1:0] ep, eb, em;
    @(posedge i_clk);
    #1;
    tick_no++;
    model_step();
    for (int c = 0; c < N_CH; c++) begin
      ep[c] = m_pulse[c] > 0;
      eb[c] = (m_pulse[c] > 0) || (m_hold[c] > 0);
      em[c] = m_missed[c];
      pulse_cnt[c] += int'(o_pulse[c]);
    end
    chk("o_pulse", 32'(o_pulse), 32'(ep));
    chk("o_busy", 32'(o_busy), 32'(eb));
    chk("o_missed", 32'(o_missed), 32'(em));
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N_CH; c++) pulse_cnt[c] = 0;
  endtask

  initial begin
    int first_hi;
    i_reset = 1'b0; i_in = 4'b0001; i_edge_mode = 2'b00; i_retrig = 1'b0;
    i_pulse_len = 8'd3; i_holdoff = 8'd0; i_clr_missed = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_hist[c] = '0; m_pulse[c] = 0; m_hold[c] = 0; m_hlat[c] = 0; m_missed[c] = 1'b0;
    end
    clear_counts();

    // input held high across reset release: one 3-cycle pulse, 2 cycles after release
    repeat (3) tick();
    chk("reset_state", 32'({o_pulse, o_busy, o_missed}), 32'd0);
    i_reset = 1'b1;
    first_hi = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (o_pulse[0] && first_hi < 0) first_hi = i;
    end
    chk("release_latency", 32'(first_hi), 32'd3);
    chk("release_pulse_len", 32'(pulse_cnt[0]), 32'd3);

    // both edges, L=1, toggle every 4 cycles
    i_edge_mode = 2'b10; i_pulse_len = 8'd1; i_holdoff = 8'd0;
    clear_counts();
    for (int i = 0; i < 28; i++) begin
      if (i % 4 == 0) i_in[1] = ~i_in[1];
      tick();
    end
    repeat (4) tick();
    chk("toggle_pulses", 32'(pulse_cnt[1]), 32'd7);
    chk("toggle_missed", 32'(o_missed[1]), 32'd0);

    // edge lands in hold-off: dropped, set beats clear in the same cycle
    i_edge_mode = 2'b00; i_pulse_len = 8'd5; i_holdoff = 8'd4;
    clear_counts();
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 6) i_in[2] = 1'b1;
      if (i == 3) i_in[2] = 1'b0;
      i_clr_missed[2] = (i == 8);
      tick();
    end
    i_clr_missed = '0;
    chk("holdoff_pulse_len", 32'(pulse_cnt[2]), 32'd5);
    chk("holdoff_missed_set_wins", 32'(o_missed[2]), 32'd1);
    i_in[2] = 1'b0; i_clr_missed[2] = 1'b1;
    tick();
    i_clr_missed = '0;
    chk("missed_cleared", 32'(o_missed[2]), 32'd0);

    // retrigger on the 3rd pulse cycle stretches to 6; without retrigger 4 and missed
    i_pulse_len = 8'd4; i_holdoff = 8'd0;
    for (int r = 1; r >= 0; r--) begin
      i_retrig = r[0];
      clear_counts();
      for (int i = 0; i < 12; i++) begin
        i_in[3] = (i != 1);
        tick();
      end
      i_in[3] = 1'b0;
      repeat (6) tick();
      chk(r ? "retrig_len" : "noretrig_len", 32'(pulse_cnt[3]), r ? 32'd6 : 32'd4);
      chk(r ? "retrig_missed" : "noretrig_missed", 32'(o_missed[3]), r ? 32'd0 : 32'd1);
    end

    // randomized traffic, shared controls changing under running pulses
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        i_edge_mode = 2'($urandom_range(0, 3));
        i_retrig = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 7) == 0) i_pulse_len = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) i_holdoff = 8'($urandom_range(0, 5));
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 3) == 0) i_in[c] = ~i_in[c];
      i_clr_missed = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      tick();
    end
    i_clr_missed = '0;

    // reset in the middle of pulses with missed flags set
    i_edge_mode = 2'b00; i_retrig = 1'b0; i_pulse_len = 8'd8; i_holdoff = 8'd2;
    i_in = '0;
    repeat (14) tick();
    i_in = '1; tick();
    i_in = '0; tick();
    i_in = '1; repeat (4) tick();
    chk("pre_reset_busy", 32'(o_pulse & o_missed), 32'hF);
    i_reset = 1'b0;
    tick();
    chk("midpulse_reset", 32'({o_pulse, o_busy, o_missed}), 32'd0);
    i_reset = 1'b1;

    // detection disabled: no pulses whatever the inputs do
    i_edge_mode = 2'b11;
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      i_in = 4'($urandom);
      tick();
    end
    chk("mode_off_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_edge_pulser.md
# multi_edge_pulser

Parametrised N-channel edge-to-pulse generator, the multi-channel successor to the single-bit positive one-shot in the channel unit. Each channel synchronises an asynchronous input, detects the selected edge type, and emits a pulse of programmable length followed by a programmable hold-off window. Dropped edges are flagged per channel. Sits between raw channel trigger inputs and the channel-unit control logic.

## Interface
- N_CH, 4: number of independent channels.
- SYNC_STAGES, 2: synchroniser flops per input (min 2).
- LEN_W, 8: width of the pulse-length field.
- HOLD_W, 8: width of the hold-off field.
- i_clk  in  1  system clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_in  in  N_CH  asynchronous trigger inputs.
- i_edge_mode  in  2  edge select, all channels: 00 rise, 01 fall, 10 both, 11 disabled.
- i_retrig  in  1  1: accepted edge during PULSE reloads length counter.
- i_pulse_len  in  LEN_W  pulse length in cycles; 0 treated as 1.
- i_holdoff  in  HOLD_W  hold-off length in cycles; 0 means none.
- i_clr_missed  in  N_CH  per-channel clear of o_missed.
- o_pulse  out  N_CH  registered output pulse.
- o_busy  out  N_CH  channel in PULSE or HOLDOFF.
- o_missed  out  N_CH  sticky: an edge was dropped.

## Operation
- Reset (i_reset=0 at a clock edge): sync chain, previous-level register, FSM, counters, o_pulse, o_busy, o_missed all 0.
- Previous level resets to 0: an input held high across reset release yields exactly one rising edge after synchroniser latency.
- Edge detect on last sync stage vs previous-level register; qualified by i_edge_mode. Mode 11 detects nothing; an in-progress pulse/hold-off still completes.
- Per-channel FSM, states IDLE, PULSE, HOLDOFF:
  - IDLE: edge -> PULSE; latch len=max(i_pulse_len,1), hold=i_holdoff into channel registers.
  - PULSE: counter decrements; on last cycle -> HOLDOFF if hold!=0 else IDLE. Edge with i_retrig=1 reloads len from current i_pulse_len, stays PULSE; edge with i_retrig=0 dropped.
  - HOLDOFF: counter decrements; last cycle -> IDLE. Any edge dropped.
- Dropped edge sets o_missed[ch]; set and i_clr_missed[ch] in same cycle: set wins.
- o_pulse[ch]=1 iff state PULSE (registered); o_busy[ch]=1 iff state != IDLE.
- Channels fully independent; shared inputs only i_edge_mode, i_retrig, i_pulse_len, i_holdoff.
- i_pulse_len/i_holdoff changes do not affect a running pulse except via retrigger reload.

## Timing
- Latency: input change settled before edge k -> o_pulse high from edge k+SYNC_STAGES (2 stages: 2 cycles after first sample).
- Pulse width exactly max(L,1) cycles; hold-off exactly H cycles immediately after.
- Back-to-back: with H=0 an edge detected in the last PULSE cycle is dropped; an edge detected the first IDLE cycle is accepted, giving one low cycle minimum between pulses.
- Minimum input pulse for detection: one high sample after synchronisation; shorter glitches may be lost (not flagged).
- Reset mid-pulse: o_pulse low on the next cycle, no residual pulse.

## Structure
- Package mep_pkg: edge-mode constants (EDGE_RISE, EDGE_FALL, EDGE_BOTH, EDGE_OFF) and FSM state encodings.
- Sub-module mep_channel: one channel (synchroniser, edge detect, FSM, counters, missed flag); top generates N_CH instances and fans out shared controls.

## Test plan
- Reset with i_in[0] held high, mode 00, L=3, H=0 -> one 3-cycle pulse on o_pulse[0] starting 2 cycles after release, none after.
- Mode 10, L=1, H=0, i_in[1] toggled every 4 cycles -> one 1-cycle pulse per toggle, latency 2, o_missed[1]=0.
- L=5, H=4, second rising edge 6 cycles after first -> single 5-cycle pulse, o_missed=1; i_clr_missed same cycle as drop -> o_missed stays 1.
- i_retrig=1, L=4, second edge on 3rd PULSE cycle -> pulse total 6 cycles; i_retrig=0 -> 4 cycles and o_missed=1.
- Reset asserted mid-pulse on all 4 channels -> o_pulse, o_busy, o_missed all 0 next cycle; mode 11 -> no pulses on any edge.
